iob_eth_dma_w: RTL



---
 rtl/iob_eth_dma_w.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_dma_w.sv
// AXI4 write-master DMA: copies a received frame from the RX buffer into memory at any byte
// address, realigning 32-bit buffer words to the destination offset and bursting with strobes.
module iob_eth_dma_w #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned BUF_START  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [AXI_ADDR_W-1:0]   dma_addr,
  input  logic [9:0]              dma_len,
  input  logic                    dma_run,
  output logic                    dma_ready,
  output logic                    dma_error,
  output logic [8:0]              out_addr,
  output logic                    out_rd,
  input  logic [31:0]             out_data
);

  localparam int unsigned BEAT_W      = 9;
  localparam int unsigned POS_W       = 12;
  localparam int unsigned OUT_ADDR_W  = 9;
  localparam int unsigned STRB_W      = AXI_DATA_W / 8;
  localparam int unsigned MAX_BURST   = 256;
  localparam int unsigned BURST_BYTES = 1024;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_RD, S_LD, S_W, S_B, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AXI_ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic                    awvalid_q, awvalid_d;
  logic [AXI_DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    wlast_q, wlast_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic [OUT_ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                    out_rd_q, out_rd_d;
  logic [1:0]              off_q, off_d;
  logic [9:0]              len_q, len_d;
  logic [BEAT_W-1:0]       nbeats_q, nbeats_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [BEAT_W-1:0]       last_q, last_d;
  logic [31:0]             cur_q, cur_d;

  logic [BEAT_W-1:0]       run_beats_c;
  logic [POS_W-1:0]        lim_c;
  logic [31:0]             align_c;
  logic [STRB_W-1:0]       strb_c;
  logic                    unused_bid;

  assign run_beats_c = BEAT_W'((POS_W'(dma_addr[1:0]) + POS_W'(dma_len) + POS_W'(3)) >> 2);
  assign lim_c       = POS_W'(off_q) + POS_W'(len_q);
  assign unused_bid  = ^m_axi_bid;

  // Byte realignment: the incoming word shifted up by the offset, low lanes filled from the previous word
  always_comb begin
    align_c = out_data;
    case (off_q)
      2'd1:    align_c = {out_data[23:0], cur_q[31:24]};
      2'd2:    align_c = {out_data[15:0], cur_q[31:16]};
      2'd3:    align_c = {out_data[7:0],  cur_q[31:8]};
      default: align_c = out_data;
    endcase
  end

  // Lane b of beat j is enabled when its frame byte index 4j+b-o falls inside [0, L)
  always_comb begin
    strb_c = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      strb_c[b] = ((POS_W'({beat_q, 2'b00}) + POS_W'(b)) >= POS_W'(off_q)) &&
                  ((POS_W'({beat_q, 2'b00}) + POS_W'(b)) < lim_c);
    end
  end

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    awvalid_d  = awvalid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    ready_d    = ready_q;
    error_d    = error_q;
    out_addr_d = out_addr_q;
    out_rd_d   = out_rd_q;
    off_d      = off_q;
    len_d      = len_q;
    nbeats_d   = nbeats_q;
    beat_d     = beat_q;
    last_d     = last_q;
    cur_d      = cur_q;
    case (state_q)
      S_IDLE: begin
        if (dma_run) begin
          ready_d  = 1'b0;
          error_d  = 1'b0;
          off_d    = dma_addr[1:0];
          len_d    = dma_len;
          nbeats_d = run_beats_c;
          beat_d   = '0;
          cur_d    = '0;
          if (run_beats_c == '0) begin
            state_d = S_DONE;
          end else begin
            awaddr_d  = {dma_addr[AXI_ADDR_W-1:2], 2'b00};
            awlen_d   = (run_beats_c > BEAT_W'(MAX_BURST)) ? 8'd255 : 8'(run_beats_c - BEAT_W'(1));
            last_d    = (run_beats_c > BEAT_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST - 1)
                                                           : run_beats_c - BEAT_W'(1);
            awvalid_d = 1'b1;
            state_d   = S_AW;
          end
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          awvalid_d  = 1'b0;
          out_rd_d   = 1'b1;
          out_addr_d = OUT_ADDR_W'(BUF_START) + OUT_ADDR_W'(beat_q);
          state_d    = S_RD;
        end
      end
      S_RD: begin
        out_rd_d = 1'b0;
        state_d  = S_LD;
      end
      S_LD: begin
        cur_d    = out_data;
        wdata_d  = AXI_DATA_W'(align_c);
        wstrb_d  = strb_c;
        wlast_d  = (beat_q == last_q);
        wvalid_d = 1'b1;
        state_d  = S_W;
      end
      S_W: begin
        if (m_axi_wready) begin
          wvalid_d = 1'b0;
          beat_d   = beat_q + BEAT_W'(1);
          if (wlast_q) begin
            bready_d = 1'b1;
            state_d  = S_B;
          end else begin
            out_rd_d   = 1'b1;
            out_addr_d = OUT_ADDR_W'(BUF_START) + OUT_ADDR_W'(beat_q + BEAT_W'(1));
            state_d    = S_RD;
          end
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          error_d  = error_q | (m_axi_bresp != 2'b00);
          // Only a frame longer than one full burst leaves beats for a second burst
          if (beat_q < nbeats_q) begin
            awaddr_d  = awaddr_q + AXI_ADDR_W'(BURST_BYTES);
            awlen_d   = 8'(nbeats_q - BEAT_W'(MAX_BURST + 1));
            last_d    = nbeats_q - BEAT_W'(1);
            awvalid_d = 1'b1;
            state_d   = S_AW;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awvalid_q  <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      ready_q    <= 1'b1;
      error_q    <= 1'b0;
      out_addr_q <= '0;
      out_rd_q   <= 1'b0;
      off_q      <= '0;
      len_q      <= '0;
      nbeats_q   <= '0;
      beat_q     <= '0;
      last_q     <= '0;
      cur_q      <= '0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wlast_q    <= wlast_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      out_addr_q <= out_addr_d;
      out_rd_q   <= out_rd_d;
      off_q      <= off_d;
      len_q      <= len_d;
      nbeats_q   <= nbeats_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
    end
  end

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd2;
  assign m_axi_awprot  = 3'b010;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign dma_ready     = ready_q;
  assign dma_error     = error_q;
  assign out_addr      = out_addr_q;
  assign out_rd        = out_rd_q;

endmodule
